// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg
// Shared types and constants for the commit trace FIFO.
//   trace_entry_t       : one buffered commit {pc, wnum, wdata, seq}
//   TRACE_DEPTH_DEFAULT : default FIFO depth
//   DROP_CNT_W          : width of the saturating drop counter
//   TRACE_SEQ_W         : width of the stored sequence field; the top's
//                         SEQ_W parameter must not exceed it
package commit_trace_pkg;

  localparam int TRACE_DEPTH_DEFAULT = 16;
  localparam int DROP_CNT_W          = 16;
  localparam int TRACE_SEQ_W         = 32;

  typedef struct packed {
    logic [63:0]            pc;
    logic [4:0]             wnum;
    logic [63:0]            wdata;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/commit_trace_mem.sv
// commit_trace_mem
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous (combinational) read port. No reset; validity of the
// contents is tracked entirely by the owning FIFO.
// Ports:
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module commit_trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Buffers the core's per-cycle commit trace and presents it to the
// difftest harness over a show-ahead valid/ready interface. Every commit
// (kept or dropped) consumes a sequence number so drops appear as gaps.
// The core cannot be stalled, so a commit into a full FIFO with no pop is
// dropped and recorded in overflow/drop_cnt.
//
// Handshake: trace_valid is high exactly when count != 0; an entry is
// consumed on a rising edge where trace_valid && trace_ready. trace_ready
// with trace_valid low has no effect.
//
// Optional feature macro: COMMIT_TRACE_ZERO_X0_EN -- when defined, commits
// to register 0 are stored with wdata forced to zero.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   debug_commit/pc/rf_wnum/wdata: commit trace from the core
//   trace_valid, trace_ready     : head handshake
//   trace_pc/wnum/wdata/seq      : head entry fields
//   count                        : occupancy (0..DEPTH)
//   overflow                     : sticky, a commit was dropped
//   drop_cnt                     : saturating count of dropped commits
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEFAULT,
  parameter int SEQ_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    debug_commit,
  input  logic [63:0]             debug_pc,
  input  logic [4:0]              debug_rf_wnum,
  input  logic [63:0]             debug_rf_wdata,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [63:0]             trace_pc,
  output logic [4:0]              trace_wnum,
  output logic [63:0]             trace_wdata,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SEQ_W-1:0] seq_ctr;
  logic             full;
  logic             pop;
  logic             push;
  trace_entry_t     wr_entry;
  trace_entry_t     rd_entry;
  trace_entry_t     hold_entry;
  trace_entry_t     head;

  assign trace_valid = (count != '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign pop         = trace_valid && trace_ready;
  // A pop in the same cycle frees the slot the write lands in, so a full
  // FIFO still accepts the commit.
  assign push        = debug_commit && (!full || pop);

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = debug_pc;
    wr_entry.wnum  = debug_rf_wnum;
`ifdef COMMIT_TRACE_ZERO_X0_EN
    wr_entry.wdata = (debug_rf_wnum == 5'd0) ? 64'h0 : debug_rf_wdata;
`else
    wr_entry.wdata = debug_rf_wdata;
`endif
    wr_entry.seq   = TRACE_SEQ_W'(seq_ctr);
  end

  commit_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_ENTRY_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // When empty, the outputs show the last head that was presented (all
  // zero after reset) rather than whatever stale slot rd_ptr points at.
  assign head        = trace_valid ? rd_entry : hold_entry;
  assign trace_pc    = head.pc;
  assign trace_wnum  = head.wnum;
  assign trace_wdata = head.wdata;
  assign trace_seq   = SEQ_W'(head.seq);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_ctr    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      hold_entry <= '0;
    end else begin
      if (debug_commit) begin
        seq_ctr <= seq_ctr + SEQ_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (debug_commit && !push) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
      end
      if (trace_valid) begin
        hold_entry <= rd_entry;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 64 + 5 + 64 + 32;

  logic        clock;
  logic        reset;
  logic        debug_commit;
  logic [63:0] debug_pc;
  logic [4:0]  debug_rf_wnum;
  logic [63:0] debug_rf_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_pc;
  logic [4:0]  trace_wnum;
  logic [63:0] trace_wdata;
  logic [31:0] trace_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .debug_commit   (debug_commit),
    .debug_pc       (debug_pc),
    .debug_rf_wnum  (debug_rf_wnum),
    .debug_rf_wdata (debug_rf_wdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_wnum     (trace_wnum),
    .trace_wdata    (trace_wdata),
    .trace_seq      (trace_seq),
    .count          (count),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [ENTRY_W-1:0] act,
                       input logic [ENTRY_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // Queue of {pc, wnum, wdata, seq}; occupancy is the queue size.
  logic [ENTRY_W-1:0] exp_q[$];
  int unsigned m_seq;
  bit          m_overflow;
  int unsigned m_drop;
  bit          m_init = 1'b0;
  bit          m_pop;
  logic [63:0] m_wd;

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_seq      = 0;
      m_overflow = 1'b0;
      m_drop     = 0;
      m_init     = 1'b1;
    end else if (m_init) begin
      m_pop = (exp_q.size() > 0) && (trace_ready == 1'b1);
      if (m_pop) void'(exp_q.pop_front());
      if (debug_commit) begin
        m_wd = debug_rf_wdata;
`ifdef COMMIT_TRACE_ZERO_X0_EN
        if (debug_rf_wnum == 5'd0) m_wd = 64'h0;
`endif
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({debug_pc, debug_rf_wnum, m_wd, m_seq[31:0]});
        end else begin
          m_overflow = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        m_seq++;
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (m_init) begin
      check("valid", ENTRY_W'(trace_valid), ENTRY_W'(exp_q.size() > 0));
      check("count", ENTRY_W'(count), ENTRY_W'(exp_q.size()));
      check("overflow", ENTRY_W'(overflow), ENTRY_W'(m_overflow));
      check("drop_cnt", ENTRY_W'(drop_cnt), ENTRY_W'(m_drop));
      if (exp_q.size() > 0) begin
        check("head", {trace_pc, trace_wnum, trace_wdata, trace_seq}, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit c, input logic [63:0] pc, input logic [4:0] wn,
                       input logic [63:0] wd, input bit rdy);
    debug_commit   = c;
    debug_pc       = pc;
    debug_rf_wnum  = wn;
    debug_rf_wdata = wd;
    trace_ready    = rdy;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 64'h0, 5'd0, 64'h0, rdy);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(1'b0);
    step();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    idle(1'b0);
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst_valid", ENTRY_W'(trace_valid), '0);
    check("rst_count", ENTRY_W'(count), '0);
    check("rst_overflow", ENTRY_W'(overflow), '0);
    check("rst_drop_cnt", ENTRY_W'(drop_cnt), '0);
    check("rst_pc", ENTRY_W'(trace_pc), '0);
    check("rst_wnum", ENTRY_W'(trace_wnum), '0);
    check("rst_wdata", ENTRY_W'(trace_wdata), '0);
    check("rst_seq", ENTRY_W'(trace_seq), '0);

    // Single commit, visible next cycle, popped the cycle after
    drive(1'b1, 64'h8000_0000, 5'd5, 64'hDEAD_BEEF, 1'b0);
    step();
    idle(1'b0);
    check("t1_valid", ENTRY_W'(trace_valid), ENTRY_W'(1));
    check("t1_seq", ENTRY_W'(trace_seq), ENTRY_W'(0));
    check("t1_count", ENTRY_W'(count), ENTRY_W'(1));
    check("t1_pc", ENTRY_W'(trace_pc), ENTRY_W'(64'h8000_0000));
    check("t1_wnum", ENTRY_W'(trace_wnum), ENTRY_W'(5));
    check("t1_wdata", ENTRY_W'(trace_wdata), ENTRY_W'(64'hDEAD_BEEF));
    idle(1'b1);
    step();
    idle(1'b0);
    check("t1_count_after_pop", ENTRY_W'(count), ENTRY_W'(0));
    check("t1_valid_after_pop", ENTRY_W'(trace_valid), ENTRY_W'(0));

    // Fill, overflow by 3, drain, next commit gets seq 19
    apply_reset();
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 64'h1000 + 64'(i), 5'(i + 1), 64'(i * 3), 1'b0);
      step();
    end
    idle(1'b0);
    check("t2_count", ENTRY_W'(count), ENTRY_W'(16));
    check("t2_overflow", ENTRY_W'(overflow), ENTRY_W'(1));
    check("t2_drop_cnt", ENTRY_W'(drop_cnt), ENTRY_W'(3));
    idle(1'b1);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_seq", ENTRY_W'(trace_seq), ENTRY_W'(i));
      step();
    end
    idle(1'b0);
    check("t2_empty", ENTRY_W'(count), ENTRY_W'(0));
    drive(1'b1, 64'h1999, 5'd3, 64'h77, 1'b0);
    step();
    idle(1'b0);
    check("t2_next_seq", ENTRY_W'(trace_seq), ENTRY_W'(19));
    check("t2_overflow_sticky", ENTRY_W'(overflow), ENTRY_W'(1));

    // Full FIFO, commit together with pop
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 64'h4000 + 64'(i), 5'd1, 64'(i), 1'b0);
      step();
    end
    drive(1'b1, 64'hAAAA, 5'd7, 64'h5555, 1'b1);
    step();
    idle(1'b0);
    check("t3_count", ENTRY_W'(count), ENTRY_W'(16));
    check("t3_overflow", ENTRY_W'(overflow), ENTRY_W'(0));
    check("t3_head_seq", ENTRY_W'(trace_seq), ENTRY_W'(1));
    idle(1'b1);
    repeat (15) step();
    check("t3_tail_pc", ENTRY_W'(trace_pc), ENTRY_W'(64'hAAAA));
    check("t3_tail_seq", ENTRY_W'(trace_seq), ENTRY_W'(16));
    check("t3_tail_wdata", ENTRY_W'(trace_wdata), ENTRY_W'(64'h5555));
    step();
    idle(1'b0);

    // Streaming: commit and pop every cycle for 100 cycles
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 64'h2000 + 64'(4 * i), 5'((i % 31) + 1), 64'(i), 1'b1);
      step();
      check("t4_count", ENTRY_W'(count), ENTRY_W'(1));
      check("t4_seq", ENTRY_W'(trace_seq), ENTRY_W'(i));
    end
    idle(1'b1);
    step();
    idle(1'b0);
    check("t4_drained", ENTRY_W'(count), ENTRY_W'(0));

    // x0 write data handling
    apply_reset();
    drive(1'b1, 64'h3000, 5'd0, 64'h1234, 1'b0);
    step();
    idle(1'b0);
`ifdef COMMIT_TRACE_ZERO_X0_EN
    check("t5_x0_wdata", ENTRY_W'(trace_wdata), ENTRY_W'(64'h0));
`else
    check("t5_x0_wdata", ENTRY_W'(trace_wdata), ENTRY_W'(64'h1234));
`endif

    // Reset mid-stream with a commit during the reset cycle
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 64'h5000 + 64'(i), 5'd2, 64'(i), 1'b0);
      step();
    end
    idle(1'b0);
    check("t6_count_before", ENTRY_W'(count), ENTRY_W'(7));
    reset = 1'b1;
    drive(1'b1, 64'h5FFF, 5'd2, 64'h9, 1'b0);
    step();
    reset = 1'b0;
    idle(1'b0);
    check("t6_count", ENTRY_W'(count), ENTRY_W'(0));
    check("t6_valid", ENTRY_W'(trace_valid), ENTRY_W'(0));
    check("t6_overflow", ENTRY_W'(overflow), ENTRY_W'(0));
    drive(1'b1, 64'h6000, 5'd4, 64'hC0DE, 1'b0);
    step();
    idle(1'b0);
    check("t6_seq_restart", ENTRY_W'(trace_seq), ENTRY_W'(0));
    check("t6_count_one", ENTRY_W'(count), ENTRY_W'(1));
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
